// File: rtl/counter.sv
// Loadable up/down counter with a programmable upper limit.
// Count saturates at 0 and at the limit; flags decode the registered state.
module counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] count_to,
  input  logic             count_inc,
  input  logic             count_dec,
  input  logic             load_en,
  output logic             flag_count_max,
  output logic             flag_count_min
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] limit_q;
  logic [WIDTH-1:0] limit_d;
  logic             do_load;
  logic             do_inc;
  logic             do_dec;

  // Mutually exclusive command decode; load wins, inc+dec together is a hold.
  assign do_load = load_en;
  assign do_inc  = !load_en && count_inc && !count_dec;
  assign do_dec  = !load_en && count_dec && !count_inc;

  // Next-state: load clamps count into the new range, inc/dec saturate.
  always_comb begin
    count_d = count_q;
    limit_d = limit_q;
    unique case (1'b1)
      do_load: begin
        limit_d = count_to;
        if (count_q > count_to)
          count_d = count_to;
      end
      do_inc: begin
        if (count_q < limit_q)
          count_d = count_q + 1'b1;
      end
      do_dec: begin
        if (count_q != '0)
          count_d = count_q - 1'b1;
      end
      default: begin
      end
    endcase
  end

  // State registers; limit resets to all-ones so counting works unloaded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      limit_q <= '1;
    end else begin
      count_q <= count_d;
      limit_q <= limit_d;
    end
  end

  // Flags are plain decodes of the registers, no extra stage.
  always_comb begin
    flag_count_max = (count_q == limit_q);
    flag_count_min = (count_q == '0);
  end

endmodule

// File: tb/tb_counter.sv
// Directed, table-driven bench for counter.
// Count is observed only through the two flags.
module tb_counter;

  logic       clk;
  logic       reset_n;
  logic [3:0] count_to;
  logic       count_inc;
  logic       count_dec;
  logic       load_en;
  logic       flag_count_max;
  logic       flag_count_min;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic       ld;
    logic       inc;
    logic       dec;
    logic [3:0] cto;
    logic       emax;
    logic       emin;
  } vec_t;

  vec_t tbl[$];

  counter #(.WIDTH(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .count_to       (count_to),
    .count_inc      (count_inc),
    .count_dec      (count_dec),
    .load_en        (load_en),
    .flag_count_max (flag_count_max),
    .flag_count_min (flag_count_min)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx,
                     input logic emax, input logic emin);
    n_cmp++;
    if (flag_count_max !== emax || flag_count_min !== emin) begin
      n_bad++;
      $display("FAIL %s[%0d]: max/min got %b/%b want %b/%b",
               nm, idx, flag_count_max, flag_count_min, emax, emin);
    end
  endtask

  task automatic add(input logic ld, input logic inc, input logic dec,
                     input logic [3:0] cto, input logic emax,
                     input logic emin);
    vec_t v;
    v.ld = ld; v.inc = inc; v.dec = dec; v.cto = cto;
    v.emax = emax; v.emin = emin;
    tbl.push_back(v);
  endtask

  task automatic cyc(input logic ld, input logic inc, input logic dec,
                     input logic [3:0] cto);
    @(negedge clk);
    load_en = ld; count_inc = inc; count_dec = dec; count_to = cto;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    // count 0, limit 15 after the hand sequences below
    add(1, 0, 0, 4'd15, 0, 1);
    for (int i = 1; i <= 20; i++)
      add(0, 1, 0, 4'd0, (i >= 15), 0);
    for (int i = 0; i < 3; i++)
      add(0, 0, 0, 4'd5, 1, 0);
    add(1, 0, 0, 4'd5, 1, 0);
    add(0, 1, 0, 4'd5, 1, 0);
    add(0, 1, 0, 4'd5, 1, 0);
    for (int i = 1; i <= 8; i++)
      add(0, 0, 1, 4'd0, 0, (i >= 5));
    for (int i = 1; i <= 3; i++)
      add(0, 1, 0, 4'd0, 0, 0);
    add(0, 1, 1, 4'd0, 0, 0);
    add(0, 1, 1, 4'd0, 0, 0);
    add(1, 1, 0, 4'd9, 0, 0);
    for (int i = 4; i <= 9; i++)
      add(0, 1, 0, 4'd0, (i == 9), 0);
    add(0, 1, 0, 4'd0, 1, 0);
    add(1, 0, 0, 4'd0, 1, 1);
    add(0, 1, 0, 4'd0, 1, 1);
    add(0, 0, 1, 4'd0, 1, 1);
    add(0, 1, 1, 4'd0, 1, 1);
    add(1, 0, 0, 4'd15, 0, 1);
    add(0, 1, 0, 4'd0, 0, 0);
    add(1, 0, 1, 4'd2, 0, 0);
    add(1, 0, 0, 4'd1, 1, 0);

    load_en = 0; count_inc = 0; count_dec = 0; count_to = 0;
    reset_n = 0;
    #12;
    chk("reset", 0, 0, 1);
    @(negedge clk);
    reset_n = 1;

    for (int i = 0; i < 7; i++) begin
      cyc(0, 1, 0, 4'd0);
      chk("pre_inc", i, (i == 14), 0);
    end

    #2;
    reset_n = 0;
    #1;
    chk("async_rst", 0, 0, 1);
    @(posedge clk);
    #1;
    chk("rst_held", 0, 0, 1);
    @(negedge clk);
    count_inc = 0;
    reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 4'd0);
      chk("post_rst", i, 0, 1);
    end

    foreach (tbl[i]) begin
      cyc(tbl[i].ld, tbl[i].inc, tbl[i].dec, tbl[i].cto);
      chk("vec", i, tbl[i].emax, tbl[i].emin);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
